// File: rtl/adc_serial_responder_if.sv
// Serial slave link between the ADC responder and its readout master.
// The master drives CNVST/CS/SCLK/DIN; the responder returns the data and status lines.
interface adc_serial_responder_if #(
  parameter int DW = 18
);
  logic          CNVST;
  logic          CS;
  logic          SCLK;
  logic [DW-1:0] DIN;
  logic          BUSY;
  logic          SDOUT;
  logic          OVERRUN;
  logic [15:0]   CONV_COUNT;

  modport slave (
    input  CNVST, CS, SCLK, DIN,
    output BUSY, SDOUT, OVERRUN, CONV_COUNT
  );

  modport master (
    output CNVST, CS, SCLK, DIN,
    input  BUSY, SDOUT, OVERRUN, CONV_COUNT
  );
endinterface

// File: rtl/adc_serial_responder.sv
// AD7643-style serial slave ADC model: converts on a CNVST fall, holds BUSY,
// then shifts the sample out MSB-first on SDOUT under the master's SCLK.
module adc_serial_responder #(
  parameter int DW          = 18,
  parameter int CONV_CYCLES = 24,
  parameter bit RAMP_MODE   = 1'b0
) (
  input logic CLK,
  input logic RESET,
  adc_serial_responder_if.slave bus
);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int BW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DATA
  } state_t;

  state_t        state_q, state_d;
  logic          cnvst_q, cnvst_prev_q;
  logic          sclk_q, sclk_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [DW-1:0] ramp_q, ramp_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;
  logic [15:0]   count_q, count_d;
  logic          cnvst_fall;
  logic          sclk_fall;

  assign cnvst_fall = cnvst_prev_q & ~cnvst_q;
  assign sclk_fall  = sclk_prev_q & ~sclk_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    ramp_d   = ramp_q;
    busy_d   = busy_q;
    ovr_d    = ovr_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (cnvst_fall) begin
          state_d = CONV;
          cnt_d   = CW'(CONV_CYCLES - 1);
          busy_d  = 1'b1;
        end
      end
      CONV: begin
        // A second start while converting is flagged, never restarts.
        if (cnvst_fall) ovr_d = 1'b1;
        if (cnt_q == '0) begin
          busy_d   = 1'b0;
          shreg_d  = RAMP_MODE ? ramp_q : bus.DIN;
          bitcnt_d = '0;
          count_d  = count_q + 16'd1;
          ramp_d   = ramp_q + DW'(1);
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnvst_fall) begin
          state_d = CONV;
          cnt_d   = CW'(CONV_CYCLES - 1);
          busy_d  = 1'b1;
        end else if (sclk_fall && !bus.CS) begin
          shreg_d  = {shreg_q[DW-2:0], 1'b0};
          bitcnt_d = bitcnt_q + BW'(1);
          if (bitcnt_q == BW'(DW - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnvst_q      <= 1'b1;
      cnvst_prev_q <= 1'b1;
      sclk_q       <= 1'b0;
      sclk_prev_q  <= 1'b0;
      cnt_q        <= '0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      ramp_q       <= '0;
      busy_q       <= 1'b0;
      ovr_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnvst_q      <= bus.CNVST;
      cnvst_prev_q <= cnvst_q;
      sclk_q       <= bus.SCLK;
      sclk_prev_q  <= sclk_q;
      cnt_q        <= cnt_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      ramp_q       <= ramp_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
      count_q      <= count_d;
    end
  end

  assign bus.BUSY       = busy_q;
  assign bus.SDOUT      = (state_q == DATA) & shreg_q[DW-1] & ~bus.CS;
  assign bus.OVERRUN    = ovr_q;
  assign bus.CONV_COUNT = count_q;
endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder: a DIN-mode and a ramp-mode instance share
// one master; reads are checked against a transaction-level model.
module tb_adc_serial_responder;
  localparam int DW = 18;
  localparam int CC = 24;

  logic CLK = 1'b0;
  logic RESET;

  adc_serial_responder_if #(.DW(DW)) a ();
  adc_serial_responder_if #(.DW(DW)) r ();

  assign r.CNVST = a.CNVST;
  assign r.CS    = a.CS;
  assign r.SCLK  = a.SCLK;
  assign r.DIN   = a.DIN;

  adc_serial_responder #(
    .DW(DW), .CONV_CYCLES(CC), .RAMP_MODE(1'b0)
  ) u_din (
    .CLK(CLK), .RESET(RESET), .bus(a.slave)
  );

  adc_serial_responder #(
    .DW(DW), .CONV_CYCLES(CC), .RAMP_MODE(1'b1)
  ) u_ramp (
    .CLK(CLK), .RESET(RESET), .bus(r.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] cs_mask;
    logic [DW-1:0] exp_word;
  } vec_t;

  vec_t vecs [4];

  int n_chk = 0;
  int n_fail = 0;

  int            exp_count;
  logic [DW-1:0] exp_ramp;
  logic          exp_ovr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse();
    a.SCLK = 1'b1;
    tick(4);
    a.SCLK = 1'b0;
    tick(4);
  endtask

  task automatic convert(input int glitch_at,
                         output logic [DW-1:0] rword);
    int bc;
    a.CNVST = 1'b0;
    tick(1);
    a.CNVST = 1'b1;
    chk("busy_early", a.BUSY, 0);
    tick(1);
    chk("busy_rise", a.BUSY, 1);
    bc = 0;
    while (a.BUSY === 1'b1 && bc < 200) begin
      bc++;
      a.CNVST = (bc == glitch_at) ? 1'b0 : 1'b1;
      tick(1);
    end
    a.CNVST = 1'b1;
    chk("busy_len", bc, CC);
    if (glitch_at > 0) exp_ovr = 1'b1;
    exp_count = (exp_count + 1) % 65536;
    rword = exp_ramp;
    exp_ramp = exp_ramp + 1'b1;
  endtask

  task automatic read_bits(input int n,
                           input logic [DW-1:0] cs_hi,
                           output logic [DW-1:0] w,
                           output logic [DW-1:0] wr);
    w  = '0;
    wr = '0;
    for (int i = 0; i < n; i++) begin
      if (cs_hi[i]) begin
        a.CS = 1'b1;
        tick(1);
        chk("cs_hi_sdout", a.SDOUT, 0);
        pulse();
        a.CS = 1'b0;
        tick(1);
      end
      w  = {w[DW-2:0], a.SDOUT};
      wr = {wr[DW-2:0], r.SDOUT};
      pulse();
    end
  endtask

  task automatic status(input string tag);
    chk({tag, "_count"}, a.CONV_COUNT, exp_count);
    chk({tag, "_ovr"}, a.OVERRUN, exp_ovr);
  endtask

  initial begin
    logic [DW-1:0] w, wr, rw, din;
    logic [DW-1:0] msk;
    int            nb, g;

    vecs[0] = '{18'h2AAAA, 18'h00000, 18'h2AAAA};
    vecs[1] = '{18'h3FFFF, 18'h001E0, 18'h3FFFF};
    vecs[2] = '{18'h00000, 18'h00000, 18'h00000};
    vecs[3] = '{18'h15555, 18'h20001, 18'h15555};

    a.CNVST = 1'b1;
    a.CS    = 1'b0;
    a.SCLK  = 1'b0;
    a.DIN   = '0;
    RESET   = 1'b1;
    exp_count = 0;
    exp_ramp  = '0;
    exp_ovr   = 1'b0;
    tick(3);
    chk("rst_busy", a.BUSY, 0);
    chk("rst_sdout", a.SDOUT, 0);
    chk("rst_ovr", a.OVERRUN, 0);
    chk("rst_count", a.CONV_COUNT, 0);
    RESET = 1'b0;
    tick(2);

    // Idle SCLK activity must not produce data
    pulse();
    chk("idle_sdout", a.SDOUT, 0);

    foreach (vecs[i]) begin
      a.DIN = vecs[i].din;
      convert(0, rw);
      read_bits(DW, vecs[i].cs_mask, w, wr);
      chk("tbl_word", w, vecs[i].exp_word);
      chk("tbl_ramp", wr, rw);
      chk("tbl_sdout_end", a.SDOUT, 0);
      chk("tbl_ramp_sdout_end", r.SDOUT, 0);
      status("tbl");
    end

    // Overrun: second start mid-conversion
    a.DIN = 18'h1234A;
    convert(10, rw);
    read_bits(DW, '0, w, wr);
    chk("ovr_word", w, 18'h1234A);
    chk("ovr_ramp", wr, rw);
    status("ovr");

    // Reset in the middle of the shift
    a.DIN = 18'h3FFFF;
    convert(0, rw);
    read_bits(9, '0, w, wr);
    chk("pre_rst_sdout", a.SDOUT, 1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_busy", a.BUSY, 0);
    chk("mid_rst_sdout", a.SDOUT, 0);
    chk("mid_rst_ovr", a.OVERRUN, 0);
    chk("mid_rst_count", a.CONV_COUNT, 0);
    tick(1);
    RESET = 1'b0;
    exp_count = 0;
    exp_ramp  = '0;
    exp_ovr   = 1'b0;
    tick(2);
    a.DIN = 18'h0F0F3;
    convert(0, rw);
    read_bits(DW, '0, w, wr);
    chk("post_rst_word", w, 18'h0F0F3);
    chk("post_rst_ramp", wr, rw);
    status("post_rst");

    // Restart after a partial read
    a.DIN = 18'h2C3A5;
    convert(0, rw);
    read_bits(7, '0, w, wr);
    chk("part_word", w, 18'h2C3A5 >> (DW - 7));
    chk("part_ramp", wr, rw >> (DW - 7));
    a.DIN = 18'h1B6E9;
    convert(0, rw);
    read_bits(DW, '0, w, wr);
    chk("restart_word", w, 18'h1B6E9);
    chk("restart_ramp", wr, rw);
    status("restart");

    for (int it = 0; it < 16; it++) begin
      din = DW'($urandom);
      msk = ($urandom_range(0, 2) == 0) ? DW'($urandom) : '0;
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : DW;
      g   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 0;
      a.DIN = din;
      convert(g, rw);
      read_bits(nb, msk, w, wr);
      chk("rnd_word", w, din >> (DW - nb));
      chk("rnd_ramp", wr, rw >> (DW - nb));
      if (nb == DW) chk("rnd_sdout_end", a.SDOUT, 0);
      status("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
